// File: rtl/firefly_flash_tx.sv
// firefly_flash_tx: firefly flash protocol transmitter.
// Emits a burst of `num` rectangular flashes on f0. Each flash is high for high_us
// microseconds, and flashes repeat every period_us microseconds. A prescaler divides
// clk by DIV to produce a 1 us tick. DIV must be at least 2.
module firefly_flash_tx #(
  parameter int unsigned DIV = 50,
  parameter int unsigned TW  = 16,
  parameter int unsigned NW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [TW-1:0] period_us,
  input  logic [TW-1:0] high_us,
  input  logic [NW-1:0] num,
  output logic          f0,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] high_q, high_d;
  logic [TW-1:0] low_q, low_d;
  logic [NW-1:0] remaining_q, remaining_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] us_q, us_d;
  logic          f0_q, f0_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;

  logic          cfg_bad;
  logic          tick;
  logic [TW-1:0] phase_len;
  logic          phase_end;

  // Config check, 1 us tick, and end-of-phase detection
  always_comb begin
    cfg_bad   = (period_us == '0) || (high_us == '0) || (high_us >= period_us) ||
                (num == '0);
    tick      = (presc_q == PRESC_MAX);
    phase_len = (state_q == ST_HIGH) ? high_q : low_q;
    // Last tick of the phase: us_q still holds the count of ticks already elapsed
    phase_end = tick && (us_q == (phase_len - TW'(1)));
  end

  // Next-state logic for the phase FSM, the timebase counters, and registered outputs
  always_comb begin
    state_d     = state_q;
    high_d      = high_q;
    low_d       = low_q;
    remaining_d = remaining_q;
    presc_d     = tick ? '0 : presc_q + PW'(1);
    us_d        = tick ? us_q + TW'(1) : us_q;
    f0_d        = f0_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        us_d    = '0;
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            high_d      = high_us;
            low_d       = period_us - high_us;
            remaining_d = num;
            state_d     = ST_HIGH;
            f0_d        = 1'b1;
            busy_d      = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (abort) begin
          state_d = ST_IDLE;
          f0_d    = 1'b0;
          busy_d  = 1'b0;
          presc_d = '0;
          us_d    = '0;
        end else if (phase_end) begin
          state_d = ST_LOW;
          f0_d    = 1'b0;
          presc_d = '0;
          us_d    = '0;
        end
      end

      ST_LOW: begin
        if (abort) begin
          state_d = ST_IDLE;
          f0_d    = 1'b0;
          busy_d  = 1'b0;
          presc_d = '0;
          us_d    = '0;
        end else if (phase_end) begin
          remaining_d = remaining_q - NW'(1);
          presc_d     = '0;
          us_d        = '0;
          if (remaining_q == NW'(1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Go straight back to HIGH with no gap, so rises stay exactly one period apart
            state_d = ST_HIGH;
            f0_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        f0_d    = 1'b0;
        busy_d  = 1'b0;
        presc_d = '0;
        us_d    = '0;
      end
    endcase
  end

  // State registers; asynchronous reset forces f0 low immediately, even mid-burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      high_q      <= '0;
      low_q       <= '0;
      remaining_q <= '0;
      presc_q     <= '0;
      us_q        <= '0;
      f0_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      high_q      <= high_d;
      low_q       <= low_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      us_q        <= us_d;
      f0_q        <= f0_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // All outputs come straight from flops
  always_comb begin
    f0      = f0_q;
    busy    = busy_q;
    done    = done_q;
    cfg_err = cfg_err_q;
  end

endmodule
